// File: rtl/opb_host_master.sv
// opb_host_master: host-command initiator for the OPB peripheral decode bus.
// Commands are queued in a small FIFO, then replayed one at a time as
// single-cycle DEC_WE / DEC_RE strobes; read data is captured and offered on
// a ready/valid response port. Only one read is ever outstanding.
module opb_host_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WR,
    input  logic [19:0] CMD_ADDR,
    input  logic [31:0] CMD_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        DEC_RE,
    output logic        DEC_WE,
    output logic [31:0] DEC_ADDR,
    output logic [31:0] DEC_DI,
    input  logic [31:0] DEC_DO,
    output logic        BUSY,
    output logic [4:0]  FIFO_LEVEL
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic        wr;
        logic [19:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef enum logic [2:0] {S_IDLE, S_WR_STB, S_RD_STB, S_RD_WAIT, S_RSP} state_t;

    cmd_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count, count_nxt;
    logic          full, push, pop;
    cmd_t          head;
    state_t        state, state_nxt;
    logic [2:0]    wait_cnt;
    logic          capture, rsp_done;

    // Ready is the only combinational output; it is held low during reset.
    assign full       = (count == 5'(FIFO_DEPTH));
    assign CMD_READY  = !full && !OPB_RST;
    assign push       = CMD_VALID && CMD_READY;
    assign head       = fifo_mem[rd_ptr];
    assign count_nxt  = count + 5'(push) - 5'(pop);
    assign FIFO_LEVEL = count;

    // Command storage; contents need no reset since count gates every read.
    always_ff @(posedge OPB_CLK) begin
        if (push) fifo_mem[wr_ptr] <= {CMD_WR, CMD_ADDR, CMD_WDATA};
    end

    // FIFO pointers and occupancy; a push into an empty FIFO is only seen next cycle.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    // Next-state logic: pops happen only from IDLE, so reads block the queue.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != 5'd0) begin
                    pop       = 1'b1;
                    state_nxt = head.wr ? S_WR_STB : S_RD_STB;
                end
            end
            S_WR_STB:  state_nxt = S_IDLE;
            S_RD_STB:  state_nxt = S_RD_WAIT;
            S_RD_WAIT: begin
                // wait_cnt is 0 in the DEC_RE-high cycle, so it equals
                // RD_LATENCY in the cycle whose closing edge samples DEC_DO.
                if (wait_cnt == 3'(RD_LATENCY)) begin
                    capture   = 1'b1;
                    state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                if (RSP_READY) begin
                    rsp_done  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and registered bus/response outputs.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            DEC_RE    <= 1'b0;
            DEC_WE    <= 1'b0;
            DEC_ADDR  <= '0;
            DEC_DI    <= '0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            BUSY      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == S_RD_WAIT) ? wait_cnt + 3'd1 : 3'd0;
            // Strobes trail the strobe state by one cycle; passing through
            // IDLE between commands guarantees a quiet cycle between strobes.
            DEC_WE   <= (state == S_WR_STB);
            DEC_RE   <= (state == S_RD_STB);
            if (pop) begin
                DEC_ADDR <= {12'd0, head.addr};
                DEC_DI   <= head.wdata;
            end
            if (capture) RSP_RDATA <= DEC_DO;
            if (capture)       RSP_VALID <= 1'b1;
            else if (rsp_done) RSP_VALID <= 1'b0;
            BUSY <= (count_nxt != 5'd0) || (state_nxt != S_IDLE);
        end
    end
endmodule

// File: tb/tb_opb_host_master.sv
// Bench for opb_host_master: two instances (read latency 1 and 3) share a
// clock and reset. A transaction-level reference model predicts every output
// each cycle; a table of single transactions and hand sequences cover the
// corner cases, then random traffic runs on both instances.
module tb_opb_host_master;
    localparam int DEPTH = 4;
    localparam int INF   = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        cmd_valid, cmd_ready, cmd_wr, rsp_valid, rsp_ready;
    logic [1:0]        dec_re, dec_we, busy;
    logic [1:0][19:0]  cmd_addr;
    logic [1:0][31:0]  cmd_wdata, rsp_rdata, dec_addr, dec_di, dec_do;
    logic [1:0][4:0]   fifo_level;

    opb_host_master #(.FIFO_DEPTH(DEPTH), .RD_LATENCY(1)) u_dut0 (
        .OPB_CLK(clk), .OPB_RST(rst),
        .CMD_VALID(cmd_valid[0]), .CMD_READY(cmd_ready[0]), .CMD_WR(cmd_wr[0]),
        .CMD_ADDR(cmd_addr[0]), .CMD_WDATA(cmd_wdata[0]),
        .RSP_VALID(rsp_valid[0]), .RSP_READY(rsp_ready[0]), .RSP_RDATA(rsp_rdata[0]),
        .DEC_RE(dec_re[0]), .DEC_WE(dec_we[0]), .DEC_ADDR(dec_addr[0]),
        .DEC_DI(dec_di[0]), .DEC_DO(dec_do[0]), .BUSY(busy[0]), .FIFO_LEVEL(fifo_level[0])
    );

    opb_host_master #(.FIFO_DEPTH(DEPTH), .RD_LATENCY(3)) u_dut1 (
        .OPB_CLK(clk), .OPB_RST(rst),
        .CMD_VALID(cmd_valid[1]), .CMD_READY(cmd_ready[1]), .CMD_WR(cmd_wr[1]),
        .CMD_ADDR(cmd_addr[1]), .CMD_WDATA(cmd_wdata[1]),
        .RSP_VALID(rsp_valid[1]), .RSP_READY(rsp_ready[1]), .RSP_RDATA(rsp_rdata[1]),
        .DEC_RE(dec_re[1]), .DEC_WE(dec_we[1]), .DEC_ADDR(dec_addr[1]),
        .DEC_DI(dec_di[1]), .DEC_DO(dec_do[1]), .BUSY(busy[1]), .FIFO_LEVEL(fifo_level[1])
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d @cyc %0d: got %h want %h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic fail_to(input string nm, input int k);
        nvec++;
        nerr++;
        $display("FAIL %s dut%0d: timed out", nm, k);
    endtask

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Decoder contents: addresses at or above 0xC0000 are unmapped and read 0.
    function automatic logic [31:0] dec_val(input logic [19:0] a);
        if (a >= 20'hC0000)     return 32'h0;
        else if (a == 20'h10000) return 32'h1234_5678;
        else                     return 32'hC0DE_0000 ^ {a, 12'h0} ^ {12'h0, a};
    endfunction

    // Reference model state, one set per instance.
    logic        mwr   [2][DEPTH];
    logic [19:0] maddr [2][DEPTH];
    logic [31:0] mdat  [2][DEPTH];
    int          mh [2], mn [2], npop [2], stb [2];
    logic        cwr [2];
    logic [19:0] caddr [2];
    logic        e_valid [2], e_busy [2], e_re [2], e_we [2], acc [2];
    logic [31:0] e_rdata [2], e_addr [2], e_di [2];
    logic        re_h [2][5];
    logic [19:0] ad_h [2][5];
    logic        prev_stb [2], prev_rv [2];
    int          stb_cnt [2], rsp_cnt [2];
    logic [31:0] wlog0 [$];

    // Per-cycle model step and output comparison, plus the decoder responder.
    // Inputs change only just after the falling edge, so values seen here are
    // the ones the preceding rising edge used.
    always @(negedge clk) begin
        int n, pre, idx;
        cyc++;
        n = cyc;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mh[k] = 0; mn[k] = 0; npop[k] = 0; stb[k] = -100;
                cwr[k] = 1'b1; caddr[k] = '0; acc[k] = 1'b0;
                e_valid[k] = 1'b0; e_busy[k] = 1'b0; e_re[k] = 1'b0; e_we[k] = 1'b0;
                e_rdata[k] = '0; e_addr[k] = '0; e_di[k] = '0;
                prev_stb[k] = 1'b0; prev_rv[k] = 1'b0;
                for (int i = 0; i < 5; i++) begin re_h[k][i] = 1'b0; ad_h[k][i] = '0; end
                dec_do[k] = '0;
                chk("rst_cmd_ready", k, 32'(cmd_ready[k]), 32'h0);
                chk("rst_outputs", k, {25'h0, dec_re[k], dec_we[k], rsp_valid[k], busy[k], 3'h0}, 32'h0);
                chk("rst_level", k, 32'(fifo_level[k]), 32'h0);
                chk("rst_dec_addr", k, dec_addr[k], 32'h0);
                chk("rst_dec_di", k, dec_di[k], 32'h0);
                chk("rst_rdata", k, rsp_rdata[k], 32'h0);
            end else begin
                if (prev_rv[k] && rsp_ready[k]) rsp_cnt[k]++;
                pre    = mn[k];
                acc[k] = cmd_valid[k] && (pre < DEPTH);
                if (e_valid[k] && rsp_ready[k]) begin
                    e_valid[k] = 1'b0;
                    npop[k]    = n + 1;
                end
                if (!cwr[k] && n == stb[k] + lat(k) + 1) begin
                    e_valid[k] = 1'b1;
                    e_rdata[k] = dec_val(caddr[k]);
                end
                if (pre > 0 && n >= npop[k]) begin
                    cwr[k]   = mwr[k][mh[k]];
                    caddr[k] = maddr[k][mh[k]];
                    e_addr[k] = {12'h0, maddr[k][mh[k]]};
                    e_di[k]   = mdat[k][mh[k]];
                    mh[k] = (mh[k] + 1) % DEPTH;
                    mn[k]--;
                    stb[k]  = n + 1;
                    npop[k] = cwr[k] ? n + 2 : INF;
                end
                if (acc[k]) begin
                    idx = (mh[k] + mn[k]) % DEPTH;
                    mwr[k][idx] = cmd_wr[k]; maddr[k][idx] = cmd_addr[k]; mdat[k][idx] = cmd_wdata[k];
                    mn[k]++;
                end
                e_we[k]   = cwr[k] && (n == stb[k]);
                e_re[k]   = !cwr[k] && (n == stb[k]);
                e_busy[k] = (mn[k] > 0) || (n < npop[k] - 1);

                chk("cmd_ready", k, 32'(cmd_ready[k]), 32'(mn[k] < DEPTH));
                chk("fifo_level", k, 32'(fifo_level[k]), 32'(mn[k]));
                chk("busy", k, 32'(busy[k]), 32'(e_busy[k]));
                chk("dec_we", k, 32'(dec_we[k]), 32'(e_we[k]));
                chk("dec_re", k, 32'(dec_re[k]), 32'(e_re[k]));
                chk("dec_addr", k, dec_addr[k], e_addr[k]);
                chk("dec_di", k, dec_di[k], e_di[k]);
                chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(e_valid[k]));
                chk("rsp_rdata", k, rsp_rdata[k], e_rdata[k]);
                chk("re_we_overlap", k, 32'(dec_re[k] & dec_we[k]), 32'h0);
                chk("strobe_gap", k, 32'(prev_stb[k] & (dec_re[k] | dec_we[k])), 32'h0);

                if (dec_re[k] || dec_we[k]) stb_cnt[k]++;
                if (k == 0 && dec_we[0]) wlog0.push_back(dec_addr[0]);
                prev_stb[k] = dec_re[k] | dec_we[k];
                prev_rv[k]  = rsp_valid[k];

                for (int i = 4; i > 0; i--) begin re_h[k][i] = re_h[k][i-1]; ad_h[k][i] = ad_h[k][i-1]; end
                re_h[k][0] = dec_re[k];
                ad_h[k][0] = dec_addr[k][19:0];
                dec_do[k]  = re_h[k][lat(k)] ? dec_val(ad_h[k][lat(k)]) : $urandom;
            end
        end
    end

    task automatic push_cmd(input int k, input logic wr, input logic [19:0] a, input logic [31:0] d);
        logic ok;
        ok = 1'b0;
        cmd_wr[k] = wr; cmd_addr[k] = a; cmd_wdata[k] = d; cmd_valid[k] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (acc[k]) begin ok = 1'b1; break; end
        end
        cmd_valid[k] = 1'b0;
        if (!ok) fail_to("push_accept", k);
    endtask

    task automatic wait_idle(input int k);
        logic ok;
        ok = 1'b0;
        rsp_ready[k] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (!e_busy[k] && !e_valid[k]) begin ok = 1'b1; break; end
        end
        if (!ok) fail_to("drain", k);
    endtask

    typedef struct {
        int          k;
        logic        wr;
        logic [19:0] addr;
        logic [31:0] wdata;
        int          stb_at;
        int          rsp_at;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [6];

    // One transaction from idle: strobe cycle, address/data, response cycle
    // and data are observed relative to the accepting edge.
    task automatic run_vec(input vec_t v);
        int fs, fr, kind;
        logic [31:0] sa, sd, rd;
        fs = 0; fr = 0; kind = 0; sa = '0; sd = '0; rd = '0;
        rsp_ready[v.k] = 1'b0;
        push_cmd(v.k, v.wr, v.addr, v.wdata);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk); #1;
            if (fs == 0 && (dec_we[v.k] || dec_re[v.k])) begin
                fs = i; kind = dec_we[v.k] ? 1 : 0; sa = dec_addr[v.k]; sd = dec_di[v.k];
            end
            if (fr == 0 && rsp_valid[v.k]) begin fr = i; rd = rsp_rdata[v.k]; end
        end
        chk("tbl_strobe_cycle", v.k, 32'(fs), 32'(v.stb_at));
        chk("tbl_strobe_kind", v.k, 32'(kind), 32'(v.wr));
        chk("tbl_strobe_addr", v.k, sa, {12'h0, v.addr});
        if (v.wr) chk("tbl_strobe_data", v.k, sd, v.wdata);
        chk("tbl_rsp_cycle", v.k, 32'(fr), 32'(v.rsp_at));
        if (!v.wr) begin
            chk("tbl_rdata", v.k, rd, v.rdata);
            chk("tbl_rsp_held", v.k, 32'(rsp_valid[v.k]), 32'h1);
            chk("tbl_rdata_held", v.k, rsp_rdata[v.k], v.rdata);
        end
        wait_idle(v.k);
    endtask

    task automatic run_random(input int k, input int ncmd);
        int sent;
        sent = 0;
        cmd_valid[k] = 1'b0;
        for (int c = 0; c < 4000 && sent < ncmd; c++) begin
            @(negedge clk); #1;
            if (cmd_valid[k] && acc[k]) begin sent++; cmd_valid[k] = 1'b0; end
            if (!cmd_valid[k] && sent < ncmd && ($urandom % 3) != 0) begin
                cmd_wr[k]    = 1'($urandom);
                cmd_addr[k]  = 20'($urandom);
                cmd_wdata[k] = $urandom;
                cmd_valid[k] = 1'b1;
            end
            rsp_ready[k] = (($urandom % 4) != 0);
        end
        cmd_valid[k] = 1'b0;
        if (sent < ncmd) fail_to("random_stream", k);
        wait_idle(k);
    endtask

    initial begin
        logic ok;
        int s0, r0;
        cmd_valid = '0; cmd_wr = '0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = '0; dec_do = '0;
        for (int k = 0; k < 2; k++) begin stb_cnt[k] = 0; rsp_cnt[k] = 0; end

        tbl[0] = '{0, 1'b1, 20'h60000, 32'hA5A5_5A5A, 2, 0, 32'h0};
        tbl[1] = '{0, 1'b0, 20'h10000, 32'h0,         2, 4, 32'h1234_5678};
        tbl[2] = '{1, 1'b0, 20'h10000, 32'h0,         2, 6, 32'h1234_5678};
        tbl[3] = '{0, 1'b0, 20'hC0010, 32'h0,         2, 4, 32'h0};
        tbl[4] = '{1, 1'b1, 20'h00FFC, 32'hDEAD_BEEF, 2, 0, 32'h0};
        tbl[5] = '{0, 1'b0, 20'h3F000, 32'h0,         2, 4, 32'hC0DE_0000 ^ 32'h3F00_0000 ^ 32'h0003_F000};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        chk("ready_after_rst", 0, 32'(cmd_ready[0]), 32'h1);
        chk("ready_after_rst", 1, 32'(cmd_ready[1]), 32'h1);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Fill: a read parked in RSP blocks the queue while 5 writes arrive.
        wlog0.delete();
        rsp_ready[0] = 1'b0;
        push_cmd(0, 1'b0, 20'h10000, 32'h0);
        repeat (4) @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) push_cmd(0, 1'b1, 20'h40000 + 20'(i * 4), $urandom);
        chk("fill_level", 0, 32'(fifo_level[0]), 32'd4);
        chk("fill_ready", 0, 32'(cmd_ready[0]), 32'h0);
        cmd_wr[0] = 1'b1; cmd_addr[0] = 20'h40010; cmd_wdata[0] = $urandom; cmd_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("fill_stall_ready", 0, 32'(cmd_ready[0]), 32'h0);
            chk("fill_stall_level", 0, 32'(fifo_level[0]), 32'd4);
        end
        rsp_ready[0] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (acc[0]) begin ok = 1'b1; break; end
        end
        cmd_valid[0] = 1'b0;
        if (!ok) fail_to("fill_fifth_accept", 0);
        wait_idle(0);
        chk("fill_wr_count", 0, 32'(wlog0.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < wlog0.size()) chk("fill_wr_order", 0, wlog0[i], 32'h40000 + 32'(i * 4));

        // Mixed stream with the response port always ready.
        wlog0.delete();
        r0 = rsp_cnt[0];
        rsp_ready[0] = 1'b1;
        push_cmd(0, 1'b1, 20'h40000, 32'h1111_2222);
        push_cmd(0, 1'b0, 20'h90000, 32'h0);
        push_cmd(0, 1'b1, 20'hA0004, 32'h3333_4444);
        wait_idle(0);
        chk("mixed_wr_count", 0, 32'(wlog0.size()), 32'd2);
        if (wlog0.size() == 2) begin
            chk("mixed_wr0", 0, wlog0[0], 32'h0004_0000);
            chk("mixed_wr1", 0, wlog0[1], 32'h000A_0004);
        end
        chk("mixed_rsp_count", 0, 32'(rsp_cnt[0] - r0), 32'd1);

        // Reset while a response is pending and two commands are queued.
        rsp_ready[0] = 1'b0;
        push_cmd(0, 1'b0, 20'h10000, 32'h0);
        repeat (5) @(negedge clk);
        #1;
        chk("pre_rst_rsp", 0, 32'(rsp_valid[0]), 32'h1);
        push_cmd(0, 1'b1, 20'h20000, 32'h5555_6666);
        push_cmd(0, 1'b1, 20'h20004, 32'h7777_8888);
        rst = 1'b1;
        #1;
        chk("async_rst_ctrl", 0, {26'h0, dec_re[0], dec_we[0], rsp_valid[0], busy[0], cmd_ready[0], 1'b0}, 32'h0);
        chk("async_rst_level", 0, 32'(fifo_level[0]), 32'h0);
        chk("async_rst_rdata", 0, rsp_rdata[0], 32'h0);
        chk("async_rst_addr", 0, dec_addr[0], 32'h0);
        chk("async_rst_di", 0, dec_di[0], 32'h0);
        @(negedge clk); #1;
        rst = 1'b0;
        rsp_ready[0] = 1'b1;
        s0 = stb_cnt[0];
        repeat (10) @(negedge clk);
        #1;
        chk("post_rst_no_strobe", 0, 32'(stb_cnt[0] - s0), 32'h0);

        run_random(0, 120);
        run_random(1, 120);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
